// File: rtl/bash_hash_ctrl.sv
// bash_hash_ctrl: sequences a BASH hash datapath. A message block is accepted
// on a valid/ready handshake and then worked for ROUNDS cycles. After a
// non-last block the controller waits for the next block; after the last
// block it presents the digest until the consumer takes it. Only the first
// block of a message latches the security level, and it must be 128, 192
// or 256. A first block with any other level is consumed and flagged.
module bash_hash_ctrl #(
   parameter int unsigned ROUNDS = 24,
   parameter int unsigned XLEN   = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_last_i,
   input  logic [XLEN-1:0] l_i,
   input  logic            abort_i,
   output logic            prep_o,
   output logic            start_o,
   output logic            work_o,
   output logic            first_o,
   output logic [XLEN-1:0] l_o,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic            busy_o,
   output logic            err_o,
   output logic [4:0]      round_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic [4:0] LastRound = 5'(ROUNDS - 1);

   state_e            state_q;
   logic [4:0]        cnt_q;
   logic [XLEN-1:0]   l_q;
   logic              last_q;
   logic              first_q;
   logic              err_q;

   logic              accept;
   logic              l_legal;

   // Handshake and datapath strobes. The strobes are combinational because
   // the datapath must sample x in the very cycle the block is accepted.
   // rst_ni gates ready so nothing can be accepted while reset is held.
   always_comb begin
      l_legal     = (l_i == XLEN'(128)) || (l_i == XLEN'(192)) || (l_i == XLEN'(256));
      req_ready_o = rst_ni && !abort_i && ((state_q == S_IDLE) || (state_q == S_WAIT));
      accept      = req_valid_i && req_ready_o;
      start_o     = accept && ((state_q == S_WAIT) || l_legal);
      prep_o      = accept && (state_q == S_IDLE) && l_legal;
      work_o      = (state_q == S_ROUND) && !abort_i;
      first_o     = (state_q == S_ROUND) && first_q && (cnt_q == 5'd0);
      round_o     = cnt_q;
      l_o         = l_q;
      out_valid_o = (state_q == S_DONE);
      busy_o      = (state_q != S_IDLE);
      err_o       = err_q;
   end

   // Control FSM together with the round counter, level, last and first flags.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         l_q     <= '0;
         last_q  <= 1'b0;
         first_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (abort_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (accept) begin
                     if (l_legal) begin
                        l_q     <= l_i;
                        last_q  <= req_last_i;
                        first_q <= 1'b1;
                        cnt_q   <= 5'd0;
                        state_q <= S_ROUND;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               S_ROUND: begin
                  // first_q only needs to survive the round-0 cycle of block 1
                  first_q <= 1'b0;
                  if (cnt_q == LastRound) begin
                     cnt_q   <= 5'd0;
                     state_q <= last_q ? S_DONE : S_WAIT;
                  end else begin
                     cnt_q <= cnt_q + 5'd1;
                  end
               end
               S_WAIT: begin
                  if (accept) begin
                     last_q  <= req_last_i;
                     cnt_q   <= 5'd0;
                     state_q <= S_ROUND;
                  end
               end
               S_DONE: begin
                  if (out_ready_i) state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bash_hash_ctrl.sv
// Testbench for bash_hash_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a timeline model of the controller. The model
// tracks how many cycles have elapsed since the current block was accepted
// and derives all expected outputs from that age.
module tb_bash_hash_ctrl;

   localparam int ROUNDS = 24;
   localparam int XLEN   = 64;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            req_valid_i, req_last_i, abort_i, out_ready_i;
   logic [XLEN-1:0] l_i;
   logic            req_ready_o, prep_o, start_o, work_o, first_o;
   logic            out_valid_o, busy_o, err_o;
   logic [XLEN-1:0] l_o;
   logic [4:0]      round_o;

   int total = 0;
   int bad   = 0;

   bash_hash_ctrl #(.ROUNDS(ROUNDS), .XLEN(XLEN)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_last_i(req_last_i), .l_i(l_i), .abort_i(abort_i),
      .prep_o(prep_o), .start_o(start_o), .work_o(work_o), .first_o(first_o),
      .l_o(l_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .busy_o(busy_o), .err_o(err_o), .round_o(round_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
      end
   endtask

   // Reference model: message activity and age of the current block in cycles.
   bit              m_active;
   int              m_age;
   bit              m_last, m_first_blk, m_err;
   logic [XLEN-1:0] m_l;
   bit              e_idle, e_wait, e_done, e_accept, e_legal;

   task automatic model_reset();
      m_active = 0; m_age = 0; m_last = 0; m_first_blk = 0; m_err = 0; m_l = '0;
   endtask

   task automatic check_outputs();
      bit in_run, e_ready;
      in_run   = m_active && m_age >= 1 && m_age <= ROUNDS;
      e_idle   = !m_active;
      e_wait   = m_active && m_age > ROUNDS && !m_last;
      e_done   = m_active && m_age > ROUNDS && m_last;
      e_legal  = (l_i == 128) || (l_i == 192) || (l_i == 256);
      e_ready  = rst_ni && !abort_i && (e_idle || e_wait);
      e_accept = req_valid_i && e_ready;
      check("ready", 64'(req_ready_o), 64'(e_ready));
      check("start", 64'(start_o), 64'(e_accept && (e_wait || e_legal)));
      check("prep",  64'(prep_o),  64'(e_accept && e_idle && e_legal));
      check("work",  64'(work_o),  64'(in_run && !abort_i));
      check("first", 64'(first_o), 64'(in_run && m_age == 1 && m_first_blk));
      check("round", 64'(round_o), in_run ? 64'(m_age - 1) : 64'd0);
      check("l_o",   l_o, m_l);
      check("valid", 64'(out_valid_o), 64'(e_done));
      check("busy",  64'(busy_o), 64'(m_active));
      check("err",   64'(err_o),  64'(m_err));
   endtask

   task automatic model_update();
      if (!rst_ni) begin
         model_reset();
         return;
      end
      m_err = e_idle && e_accept && !e_legal;
      if (abort_i) begin
         m_active = 0;
      end else if (e_accept && (e_wait || e_legal)) begin
         if (e_idle) m_l = l_i;
         m_first_blk = e_idle;
         m_active    = 1;
         m_age       = 1;
         m_last      = req_last_i;
      end else if (e_done && out_ready_i) begin
         m_active = 0;
      end else if (m_active && m_age <= ROUNDS) begin
         m_age++;
      end
   endtask

   // One clock cycle: drive inputs, check on the falling edge, advance model.
   task automatic cyc(input bit v, input bit last, input logic [XLEN-1:0] l,
                      input bit ab, input bit ordy);
      req_valid_i = v; req_last_i = last; l_i = l; abort_i = ab; out_ready_i = ordy;
      @(negedge clk_i);
      check_outputs();
      @(posedge clk_i);
      model_update();
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0);
   endtask

   function automatic logic [XLEN-1:0] pick_level();
      case ($urandom_range(0, 4))
         0:       return 128;
         1:       return 192;
         2:       return 256;
         3:       return 160;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      model_reset();
      rst_ni = 1'b0;
      req_valid_i = 0; req_last_i = 0; l_i = '0; abort_i = 0; out_ready_i = 0;
      // Reset held with a request presented: nothing may be accepted.
      cyc(1, 1, 256, 0, 1);
      cyc(1, 1, 256, 0, 1);
      rst_ni = 1'b1;
      idle_cycles(1);

      // Single last block, level 256.
      cyc(1, 1, 256, 0, 0);
      idle_cycles(ROUNDS);
      cyc(0, 0, '0, 0, 1);
      idle_cycles(2);

      // Three blocks at level 192, digest held for 10 cycles.
      cyc(1, 0, 192, 0, 0);
      idle_cycles(ROUNDS + 2);
      cyc(1, 0, 128, 0, 0);
      idle_cycles(ROUNDS + 1);
      cyc(1, 1, 5, 0, 0);
      idle_cycles(ROUNDS + 10);
      cyc(0, 0, '0, 0, 1);
      idle_cycles(1);

      // Illegal level on a first block.
      cyc(1, 1, 160, 0, 0);
      idle_cycles(2);

      // Abort at round 7 of block 2, then a full message.
      cyc(1, 0, 128, 0, 0);
      idle_cycles(ROUNDS);
      cyc(1, 0, 0, 0, 0);
      idle_cycles(7);
      cyc(0, 0, '0, 1, 1);
      idle_cycles(2);
      cyc(1, 1, 256, 0, 0);
      idle_cycles(ROUNDS);
      cyc(0, 0, '0, 0, 1);

      // Abort and out_ready together in DONE.
      cyc(1, 1, 192, 0, 0);
      idle_cycles(ROUNDS + 1);
      cyc(0, 0, '0, 1, 1);
      idle_cycles(1);

      // Reset asserted at round 12: outputs drop immediately.
      cyc(1, 1, 256, 0, 0);
      idle_cycles(12);
      rst_ni = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk_i);
      #1;
      idle_cycles(2);
      rst_ni = 1'b1;
      idle_cycles(2);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 1) == 1, $urandom_range(0, 4) < 2, pick_level(),
             $urandom_range(0, 99) < 2, $urandom_range(0, 9) < 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
